// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor: W bits cut into N-bit skip blocks,
// B blocks resolved per stage, valid/ready handshake on both sides.
module pipelined_carry_skip_adder #(
  parameter int W = 32,
  parameter int N = 4,
  parameter int B = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int NB = N * B;
  localparam int S  = (NB > 0) ? W / NB : 1;

  if (N < 1 || B < 1 || W < 1 || (W % N) != 0 || ((W / N) % B) != 0) begin : g_param_check
    $error("pipelined_carry_skip_adder: W must be a multiple of N, and W/N a multiple of B");
  end

  logic [S-1:0] stage_valid;
  logic [S-1:0] load;

  // A stage can load unless it and every stage after it are full while the
  // consumer stalls; this is the only combinational path from out_ready.
  always_comb begin : load_chain
    logic all_full;
    // NOTE: every variable written here gets a value before any branch or loop,
    // so no path through the block can leave a stale value and infer a latch.
    all_full = 1'b1;
    load     = '0;
    for (int k = S - 1; k >= 0; k--) begin
      all_full = all_full & stage_valid[k];
      load[k]  = out_ready | ~all_full;
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < S; k++) begin : g_stage
    // Operand bits not yet consumed when entering this stage.
    localparam int REM = W - k * NB;

    logic [REM-1:0]      a_in, bp_in;
    logic                c_in, v_in;
    logic [NB-1:0]       p_s, g_s, c_bit, slice_sum;
    logic                c_out;
    logic [(k+1)*NB-1:0] sum_full;

    logic                valid_q, valid_d;
    logic                carry_q, carry_d;
    logic [(k+1)*NB-1:0] sum_q, sum_d;

    if (k == 0) begin : g_src
      assign a_in     = a;
      assign bp_in    = sub ? ~b : b;
      assign c_in     = sub | cin;
      assign v_in     = in_valid;
      assign sum_full = slice_sum;
    end else begin : g_src
      assign a_in     = g_stage[k-1].g_fwd.a_q;
      assign bp_in    = g_stage[k-1].g_fwd.bp_q;
      assign c_in     = g_stage[k-1].carry_q;
      assign v_in     = g_stage[k-1].valid_q;
      assign sum_full = {slice_sum, g_stage[k-1].sum_q};
    end

    assign p_s = a_in[NB-1:0] ^ bp_in[NB-1:0];
    assign g_s = a_in[NB-1:0] & bp_in[NB-1:0];

    // Ripple inside each block; when the whole block propagates, the block
    // carry-in bypasses the ripple chain through the skip mux.
    always_comb begin : carry_skip
      logic c, blk_cin, all_p;
      c       = c_in;
      blk_cin = 1'b0;
      all_p   = 1'b0;
      c_bit   = '0;
      for (int j = 0; j < B; j++) begin
        blk_cin = c;
        all_p   = 1'b1;
        for (int i = 0; i < N; i++) begin
          c_bit[j*N+i] = c;
          c            = g_s[j*N+i] | (p_s[j*N+i] & c);
          all_p        = all_p & p_s[j*N+i];
        end
        c = all_p ? blk_cin : c;
      end
      c_out = c;
    end

    assign slice_sum = p_s ^ c_bit;

    always_comb begin : stage_next
      valid_d = valid_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      if (load[k]) begin
        valid_d = v_in;
        if (v_in) begin
          carry_d = c_out;
          sum_d   = sum_full;
        end
      end
    end

    // NOTE: data flops are reset along with valid so the outputs read zero
    // after reset and nothing from a discarded beat can leak out.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of its neighbours, independent of block order.
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    assign stage_valid[k] = valid_q;

    if (k < S - 1) begin : g_fwd
      logic [REM-NB-1:0] a_q, a_d, bp_q, bp_d;

      always_comb begin
        a_d  = a_q;
        bp_d = bp_q;
        if (load[k] && v_in) begin
          a_d  = a_in[REM-1:NB];
          bp_d = bp_in[REM-1:NB];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q  <= '0;
          bp_q <= '0;
        end else begin
          a_q  <= a_d;
          bp_q <= bp_d;
        end
      end
    end else begin : g_last
      // Carry into the MSB, kept for the overflow flag.
      logic c_msb_q, c_msb_d;

      always_comb begin
        c_msb_d = c_msb_q;
        if (load[k] && v_in) c_msb_d = c_bit[NB-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) c_msb_q <= 1'b0;
        else     c_msb_q <= c_msb_d;
      end
    end
  end

  assign out_valid = g_stage[S-1].valid_q;
  assign sum       = g_stage[S-1].sum_q;
  assign cout      = g_stage[S-1].carry_q;
  assign ovf       = g_stage[S-1].g_last.c_msb_q ^ g_stage[S-1].carry_q;

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Randomised and directed checks of pipelined_carry_skip_adder against a
// plain-arithmetic reference model; three parameter configurations.
module tb_pipelined_carry_skip_adder;

  localparam int W   = 32, N = 4, B = 2, S = 4;
  localparam int S8  = 1;
  localparam int S64 = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main configuration
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  // Sweep configurations
  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        in_valid64, in_ready64, cin64, sub64, out_valid64, cout64, ovf64;
  logic [63:0] a64, b64, sum64;
  logic        out_ready_sw;

  pipelined_carry_skip_adder #(.W(W), .N(N), .B(B)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

  pipelined_carry_skip_adder #(.W(8), .N(2), .B(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready_sw), .sum(sum8), .cout(cout8), .ovf(ovf8));

  pipelined_carry_skip_adder #(.W(64), .N(8), .B(1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .a(a64), .b(b64), .cin(cin64), .sub(sub64), .out_valid(out_valid64),
    .out_ready(out_ready_sw), .sum(sum64), .cout(cout64), .ovf(ovf64));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from ordinary (w+1)-bit arithmetic.
  function automatic logic [65:0] model(input logic [63:0] a_i, input logic [63:0] b_i,
                                        input logic cin_i, input logic sub_i, input int w);
    logic [63:0] mask, bp, s;
    logic [64:0] t;
    logic        co, ov;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    bp   = (sub_i ? ~b_i : b_i) & mask;
    t    = {1'b0, a_i & mask} + {1'b0, bp} + (sub_i ? 65'd1 : {64'd0, cin_i});
    s    = t[63:0] & mask;
    co   = t[w];
    ov   = (a_i[w-1] == bp[w-1]) && (s[w-1] != a_i[w-1]);
    return {ov, co, s};
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] corners [4];
    corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  // ---------------- main scoreboard / compare process ----------------
  typedef struct { logic [31:0] s; logic co; logic ov; } res_t;
  res_t        sb[$];
  logic        hold_pend = 1'b0;
  logic [33:0] held;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold_pend = 1'b0;
    end else begin
      check("in_ready_vs_occupancy", in_ready, !(sb.size() == S && !out_ready));
      if (hold_pend) begin
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_hold", {ovf, cout, sum}, held);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_result", 1'b1, 1'b0);
        else begin
          automatic res_t e = sb.pop_front();
          check("sum", sum, e.s);
          check("cout", cout, e.co);
          check("ovf", ovf, e.ov);
        end
      end
      if (in_valid && in_ready) begin
        automatic logic [65:0] r = model({32'd0, a}, {32'd0, b}, cin, sub, 32);
        sb.push_back('{r[31:0], r[64], r[65]});
      end
      hold_pend = out_valid && !out_ready;
      held      = {ovf, cout, sum};
    end
  end

  // ---------------- sweep checkers (latency measured in edges) ----------------
  typedef struct { logic [65:0] r; int e; } sw_t;
  sw_t q8[$], q64[$];
  int  cyc = 0;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      q64.delete();
    end else begin
      if (out_valid8) begin
        if (q8.size() == 0) check("sw8_spurious", 1'b1, 1'b0);
        else begin
          automatic sw_t x = q8.pop_front();
          check("sw8_result", {ovf8, cout8, sum8}, {x.r[65], x.r[64], x.r[7:0]});
          check("sw8_latency", cyc - x.e, S8 - 1);
        end
      end
      if (out_valid64) begin
        if (q64.size() == 0) check("sw64_spurious", 1'b1, 1'b0);
        else begin
          automatic sw_t x = q64.pop_front();
          check("sw64_result", {ovf64, cout64, sum64}, x.r);
          check("sw64_latency", cyc - x.e, S64 - 1);
        end
      end
      if (in_valid8) begin
        check("sw8_in_ready", in_ready8, 1'b1);
        if (in_ready8) q8.push_back('{model({56'd0, a8}, {56'd0, b8}, cin8, sub8, 8), cyc + 1});
      end
      if (in_valid64) begin
        check("sw64_in_ready", in_ready64, 1'b1);
        if (in_ready64) q64.push_back('{model(a64, b64, cin64, sub64, 64), cyc + 1});
      end
    end
  end

  // Single beat with literal expectations and a latency measurement.
  task automatic run_one(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                         input logic tsub, input logic [31:0] es, input logic eco,
                         input logic eov, input string name);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({name, "_accept"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, S - 1);
    check({name, "_sum"}, sum, es);
    check({name, "_cout"}, cout, eco);
    check({name, "_ovf"}, ovf, eov);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; out_ready = 1; a = 0; b = 0; cin = 0; sub = 0;
    in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    in_valid64 = 0; a64 = 0; b64 = 0; cin64 = 0; sub64 = 0;
    out_ready_sw = 1;

    // Pin the reference model to hand-computed values.
    check("model_pin_wrap", model(64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 32), {2'b01, 64'h0});
    check("model_pin_sub", model(64'h8000_0000, 64'h1, 1'b0, 1'b1, 32), {2'b11, 64'h7FFF_FFFF});
    check("model_pin_ovf8", model(64'h7F, 64'h01, 1'b0, 1'b0, 8), {2'b10, 64'h80});

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", {ovf, cout, sum}, 34'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1'b1);

    // Directed: full skip chain, subtract overflow, subtract borrow
    run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "skip_chain");
    run_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
    run_one(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_borrow");
    run_one(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "cin_ovf");

    // Stall: fill four stages, fifth beat refused, output held, then drain
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < S; i++) begin
      a = 32'h1111_1111 * (i + 1); b = 32'h0F0F_0F0F + i; cin = i[0]; sub = i[1];
      #1 check("fill_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
    end
    a = 32'hDEAD_BEEF;
    #1 check("fifth_beat_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    begin
      logic [31:0] held_sum;
      held_sum = sum;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        check("stall10_sum", sum, held_sum);
      end
    end
    out_ready = 1'b1;
    #1 check("release_in_ready", in_ready, 1'b1);
    for (int i = 0; i < S; i++) begin
      check("drain_out_valid", out_valid, 1'b1);
      @(posedge clk); #2;
    end
    check("drained_out_valid", out_valid, 1'b0);

    // Reset with three beats in flight
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h1234_5678 + i; b = 32'h0101_0101; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("inflight_out_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_sum", sum, 32'd0);
    check("async_rst_flags", {ovf, cout}, 2'b00);
    @(negedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    run_one(32'd5, 32'd7, 1'b1, 1'b0, 32'd13, 1'b0, 1'b0, "after_rst");

    // Random traffic: 1000 accepted beats with random in_valid/out_ready
    begin
      int acc, cycles, w;
      acc = 0; cycles = 0;
      while (acc < 1000 && cycles < 20000) begin
        @(posedge clk); #1;
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        a = pick32(); b = pick32(); cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
        #1;
        if (in_valid && in_ready) acc++;
        cycles++;
      end
      check("random_beats_accepted", acc, 1000);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      w = 0;
      while (sb.size() != 0 && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      check("random_drain_empty", sb.size(), 0);
    end

    // Sweep: exhaustive 8-bit operands, random 64-bit operands, streaming
    @(posedge clk); #1;
    in_valid8 = 1'b1; in_valid64 = 1'b1;
    for (int n = 0; n < 65536; n++) begin
      a8 = n[15:8]; b8 = n[7:0];
      cin8 = $urandom_range(0, 1); sub8 = $urandom_range(0, 1);
      if (n % 16 == 0) begin a64 = {64{1'b1}}; b64 = 64'd1; end
      else begin a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; end
      cin64 = $urandom_range(0, 1); sub64 = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0; in_valid64 = 1'b0;
    repeat (S64 + 4) @(posedge clk);
    #1 check("sweep_drain_empty", q8.size() + q64.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_skip_adder.md
# pipelined_carry_skip_adder

Parametrised, pipelined carry-skip (carry-bypass) adder/subtractor with valid/ready flow control on both sides. The operand word is cut into N-bit skip blocks, and B blocks are evaluated per pipeline stage. The design sustains one operation per cycle at a clock rate independent of W. It sits between operand-producing and result-consuming datapath blocks, either of which can stall.

## Interface
- W, 32: operand/result width in bits.
- N, 4: skip-block width in bits. W % N must be 0.
- B, 2: skip blocks per pipeline stage. (W/N) % B must be 0. Stage count is S = W/(N*B).
- Illegal parameter combinations must fail elaboration.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a−b, computed as a+~b+1.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  W  result bits [W-1:0].
- cout  out  1  carry out of bit W-1. In subtract mode, 1 means no borrow.
- ovf  out  1  two's-complement overflow: carry into bit W-1 XOR cout.

## Operation
- Per bit: p = a^b' and g = a&b', where b' = sub ? ~b : b. Carry-in to block 0 is sub ? 1 : cin.
- Per block: ripple the carry across N bits. Block carry-out = (&p_block) ? block carry-in : ripple carry-out. Sum bit = p ^ carry-in of that bit.
- Stage k (0..S-1) computes blocks k*B .. k*B+B-1 from the carry registered by stage k-1. Stage 0 uses the block-0 carry-in.
- Each stage register holds:
  - valid
  - the stage's carry-out
  - all sum bits produced so far
  - the still-unprocessed upper slices of a and b' (inversion is applied once, at stage 0)
  - for the last stage only: carry into bit W-1, used for ovf
- Stage S-1's register drives sum, cout, ovf and out_valid directly. The outputs are registered; there is no combinational path from a/b to sum.
- Flow control:
  - Stage k may load when its register is empty, or when its contents move to stage k+1 (or to the consumer) in the same cycle.
  - in_ready = stage-0 load enable. It may depend combinationally on out_ready through the chain. No other input-to-output combinational path is allowed.
  - A beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
  - Stalled stages hold their data unchanged. Bubbles collapse: an empty stage always accepts from the stage before it.
- Reset: asynchronous assert clears every valid bit, carry, and data register to 0. Outputs go to in_ready=1 (after reset deasserts), out_valid=0, sum=0, cout=0, ovf=0. A reset in mid-flight discards all in-flight beats; no partial result is ever emitted.

## Timing
- Latency: a beat accepted on edge t is presented with out_valid=1 starting in the cycle after edge t+S-1. Its outputs are stable until consumed. With S=1 this is one cycle.
- Throughput: 1 beat/cycle while out_ready=1. Up to S beats are buffered.
- Full pipeline with out_ready=0: in_ready=0 in that same cycle. When out_ready returns to 1, in_ready=1 in the same cycle, and the pipe shifts on the next edge.
- Simultaneous accept and consume when full: both occur, and occupancy is unchanged.
- out_valid=1 with out_ready=0: sum, cout and ovf must not change until consumed.
- Wrap-around: sums are mod 2^W. The excess appears only on cout.
- Critical path per stage: at most B*N ripple bits plus B skip muxes.

## Test plan
- W=32, N=4, B=2 (S=4), out_ready=1: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 → result 4 cycles later: sum=0x00000000, cout=1, ovf=0. This carry passes through every skip mux.
- sub=1, a=0x80000000, b=0x00000001 → sum=0x7FFFFFFF, cout=1, ovf=1. Then a=0x00000000, b=0x00000001 → sum=0xFFFFFFFF, cout=0, ovf=0.
- Back-to-back 1000 random beats with random in_valid and out_ready. Results must match a+b'+cin from a reference model, in order, with no loss or duplication. in_ready must be 0 exactly when all 4 stages are full and out_ready=0.
- Hold out_ready=0 and issue 4 beats: the 5th beat sees in_ready=0, and sum stays stable across 10 stall cycles. Release → drain 4 results on consecutive cycles.
- Assert rst mid-stream with 3 beats in flight: out_valid=0 and sum=0 immediately (asynchronously). After release, the first new beat a=5, b=7, cin=1 yields sum=13 after 4 cycles, with no stale output.
- Parameter sweep (W=8, N=2, B=4, S=1) and (W=64, N=8, B=1, S=8): exhaustive for 8 bits, random for 64 bits. Latency must equal S in every configuration.
